// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Owns the main memory (2^AW words of DW bits) and shares its single port
// between the CPU and the loader/debug port. Grants alternate round-robin on
// contention. A requester may set lock on an access to keep the port for its
// next access (atomic read-modify-write). A lock left idle for LOCK_TMO cycles
// is dropped and reported on lock_err.
//
// Ports
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   c_req/c_we/c_lock        CPU request, write flag, keep-ownership flag
//   c_addr/c_wdata           CPU address and write data
//   c_gnt                    CPU access performed at the end of this cycle
//   c_rvalid/c_rdata         CPU read return (rdata holds its last value)
//   l_*                      loader port, same meaning as the CPU port
//   lock_err                 one-cycle pulse when a held lock times out
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int LOCK_TMO = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          lock_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, GNT, HOLD} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

  state_t        state, state_d;
  owner_t        owner, owner_d;
  owner_t        last, last_d;
  logic [7:0]    tmo_cnt, tmo_cnt_d;
  logic          c_gnt_d, l_gnt_d, c_rvalid_d, l_rvalid_d, lock_err_d;
  logic          do_access;
  logic [DW-1:0] mem [DEPTH];

  // The current owner's request fields; only meaningful in GNT and HOLD.
  logic          sel_ldr;
  logic          acc_req, acc_we, acc_lock;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  assign sel_ldr   = (owner == OWN_LDR);
  assign acc_req   = sel_ldr ? l_req   : c_req;
  assign acc_we    = sel_ldr ? l_we    : c_we;
  assign acc_lock  = sel_ldr ? l_lock  : c_lock;
  assign acc_addr  = sel_ldr ? l_addr  : c_addr;
  assign acc_wdata = sel_ldr ? l_wdata : c_wdata;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state;
    owner_d    = owner;
    last_d     = last;
    tmo_cnt_d  = tmo_cnt;
    c_gnt_d    = 1'b0;
    l_gnt_d    = 1'b0;
    c_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    lock_err_d = 1'b0;
    do_access  = 1'b0;

    unique case (state)
      IDLE: begin
        // On contention the requester that was not served last wins.
        if (c_req && (!l_req || last == OWN_LDR)) begin
          state_d = GNT;
          owner_d = OWN_CPU;
          c_gnt_d = 1'b1;
        end else if (l_req) begin
          state_d = GNT;
          owner_d = OWN_LDR;
          l_gnt_d = 1'b1;
        end
      end

      GNT: begin
        do_access = 1'b1;
        last_d    = owner;
        tmo_cnt_d = '0;
        if (!acc_we) begin
          c_rvalid_d = !sel_ldr;
          l_rvalid_d = sel_ldr;
        end
        if (acc_lock) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end

      HOLD: begin
        // The other requester is ignored until the lock ends or times out.
        if (acc_req) begin
          state_d   = GNT;
          tmo_cnt_d = '0;
          c_gnt_d   = !sel_ldr;
          l_gnt_d   = sel_ldr;
        end else if (tmo_cnt == 8'(LOCK_TMO - 1)) begin
          state_d    = IDLE;
          owner_d    = OWN_NONE;
          tmo_cnt_d  = '0;
          lock_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      last     <= OWN_LDR;
      tmo_cnt  <= '0;
      c_gnt    <= 1'b0;
      l_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      lock_err <= 1'b0;
      c_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_d;
      owner    <= owner_d;
      last     <= last_d;
      tmo_cnt  <= tmo_cnt_d;
      c_gnt    <= c_gnt_d;
      l_gnt    <= l_gnt_d;
      c_rvalid <= c_rvalid_d;
      l_rvalid <= l_rvalid_d;
      lock_err <= lock_err_d;
      if (do_access && !acc_we) begin
        if (sel_ldr) l_rdata <= mem[acc_addr];
        else         c_rdata <= mem[acc_addr];
      end
    end
  end

  // Memory array. A write caught by reset at the closing edge never commits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the array is small and must read as zero after reset, so it is
      // built from resettable flops rather than an un-reset RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_access && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int LOCK_TMO = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          c_req, c_we, c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          l_req, l_we, l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid, lock_err;
  logic [DW-1:0] c_rdata, l_rdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_TMO(LOCK_TMO)) dut (
    .CLK(CLK), .RST(RST),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .lock_err(lock_err)
  );

  // One requested access; lat >= 0 asks the driver to check grant latency.
  typedef struct {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } tx_t;

  typedef enum {EV_GNT, EV_ERR} ev_kind_t;
  // Expected observable event, in the order the arbitration rules dictate.
  typedef struct {
    ev_kind_t      kind;
    bit            who;    // 0 = CPU, 1 = loader
    logic          we;
    logic [DW-1:0] rdata;
  } ev_t;

  tx_t           cpu_q[$];
  tx_t           ldr_q[$];
  ev_t           exp_q[$];
  logic [DW-1:0] mdl_mem [16];
  bit            mdl_last;      // requester served most recently (1 = loader)
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- model ---
  function automatic void mdl_reset();
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    mdl_last = 1'b1;
  endfunction

  function automatic tx_t mk(input logic we, input logic lock, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int lat);
    tx_t t;
    t.we = we; t.lock = lock; t.addr = a; t.wdata = d; t.lat = lat;
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    return mk(1'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, 15)),
              DW'($urandom_range(0, 255)), -1);
  endfunction

  // Record that 'who' is served next: apply to the model memory, queue the
  // expected grant and hand the access to that requester's driver.
  task automatic issue(input bit who, input tx_t t, output logic [DW-1:0] rd);
    ev_t e;
    rd = mdl_mem[t.addr];
    if (t.we) mdl_mem[t.addr] = t.wdata;
    e.kind = EV_GNT; e.who = who; e.we = t.we; e.rdata = rd;
    exp_q.push_back(e);
    mdl_last = who;
    if (who) ldr_q.push_back(t);
    else     cpu_q.push_back(t);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = EV_ERR; e.who = 1'b0; e.we = 1'b0; e.rdata = '0;
    exp_q.push_back(e);
  endtask

  // -------------------------------------------------------------- drivers ---
  task automatic set_port(input bit who, input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      l_req = req; l_we = we; l_lock = lock; l_addr = a; l_wdata = d;
    end else begin
      c_req = req; c_we = we; c_lock = lock; c_addr = a; c_wdata = d;
    end
  endtask

  function automatic logic gnt_of(input bit who);
    return who ? l_gnt : c_gnt;
  endfunction

  task automatic run_port(input bit who);
    tx_t t;
    int  waited;
    while ((who ? ldr_q.size() : cpu_q.size()) != 0) begin
      if (who) t = ldr_q.pop_front();
      else     t = cpu_q.pop_front();
      set_port(who, 1'b1, t.we, t.lock, t.addr, t.wdata);
      waited = 0;
      do begin
        @(posedge CLK); #1;
        waited++;
      end while (!gnt_of(who) && waited < 200);
      if (!gnt_of(who)) begin
        check(who ? "l_gnt_timeout" : "c_gnt_timeout", 32'(gnt_of(who)), 32'd1);
        set_port(who, 1'b0, 1'b0, 1'b0, '0, '0);
        if (who) ldr_q.delete();
        else     cpu_q.delete();
        return;
      end
      if (t.lat >= 0) check(who ? "l_gnt_latency" : "c_gnt_latency", 32'(waited), 32'(t.lat));
      @(posedge CLK); #1;
      set_port(who, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  bit rv_pending = 1'b0;

  task automatic run_round();
    int waited;
    fork
      run_port(1'b0);
      run_port(1'b1);
    join
    waited = 0;
    while ((exp_q.size() != 0 || rv_pending) && waited < 100) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (exp_q.size() != 0 || rv_pending) begin
      check("drain_events", 32'(exp_q.size()) + 32'(rv_pending), 32'd0);
      exp_q.delete();
      rv_pending = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  task automatic round_single(input bit who, input tx_t t);
    logic [DW-1:0] rd;
    t.lat = 1;
    issue(who, t, rd);
    run_round();
  endtask

  // Both requesters start together; they alternate while both have work.
  task automatic round_pair(input int nc, input int nl);
    tx_t           ca[$], la[$];
    logic [DW-1:0] rd;
    bit            w;
    for (int i = 0; i < nc; i++) ca.push_back(rnd_tx());
    for (int i = 0; i < nl; i++) la.push_back(rnd_tx());
    while (ca.size() != 0 && la.size() != 0) begin
      w = !mdl_last;
      if (w) issue(1'b1, la.pop_front(), rd);
      else   issue(1'b0, ca.pop_front(), rd);
    end
    while (ca.size() != 0) issue(1'b0, ca.pop_front(), rd);
    while (la.size() != 0) issue(1'b1, la.pop_front(), rd);
    run_round();
  endtask

  // Requester lk does a locked read of addr then either writes back
  // (2*v or ~v, unlocked) or abandons the lock; the other requester issues o
  // at the same time.
  task automatic round_lock(input bit lk, input logic [AW-1:0] addr, input bit cpl,
                            input tx_t o, input bit tmo);
    logic [DW-1:0] v, rd;
    bit            other_done = 1'b0;
    if (mdl_last == lk) begin
      issue(!lk, o, rd);
      other_done = 1'b1;
    end
    issue(lk, mk(1'b0, 1'b1, addr, '0, -1), v);
    if (tmo) push_err();
    else     issue(lk, mk(1'b1, 1'b0, addr, cpl ? ~v : DW'(v << 1), -1), rd);
    if (!other_done) issue(!lk, o, rd);
    run_round();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    mdl_reset();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_c_gnt"},    32'(c_gnt),    32'd0);
    check({tag, "_l_gnt"},    32'(l_gnt),    32'd0);
    check({tag, "_c_rvalid"}, 32'(c_rvalid), 32'd0);
    check({tag, "_l_rvalid"}, 32'(l_rvalid), 32'd0);
    check({tag, "_lock_err"}, 32'(lock_err), 32'd0);
    check({tag, "_c_rdata"},  32'(c_rdata),  32'd0);
    check({tag, "_l_rdata"},  32'(l_rdata),  32'd0);
  endtask

  // -------------------------------------------------------------- monitor ---
  bit            rv_who = 1'b0;
  logic [DW-1:0] rv_data = '0;
  bit            prev_gnt = 1'b0;
  int            cyc = 0;
  int            last_gnt_cyc = 0;
  logic [DW-1:0] held_c = '0, held_l = '0;

  always @(negedge CLK) begin : monitor
    bit            exp_rv;
    bit            exp_who;
    logic [DW-1:0] exp_d;
    ev_t           e;
    if (RST) begin
      rv_pending = 1'b0;
      prev_gnt   = 1'b0;
      held_c     = '0;
      held_l     = '0;
    end else begin
      cyc++;
      exp_rv     = rv_pending;
      exp_who    = rv_who;
      exp_d      = rv_data;
      rv_pending = 1'b0;

      if (exp_rv || c_rvalid || l_rvalid) begin
        check("c_rvalid", 32'(c_rvalid), 32'(exp_rv && !exp_who));
        check("l_rvalid", 32'(l_rvalid), 32'(exp_rv && exp_who));
        if (exp_rv) begin
          if (exp_who) held_l = exp_d;
          else         held_c = exp_d;
        end
        check("c_rdata", 32'(c_rdata), 32'(held_c));
        check("l_rdata", 32'(l_rdata), 32'(held_l));
      end

      if (c_gnt || l_gnt) begin
        check("one_gnt_only", 32'(c_gnt && l_gnt), 32'd0);
        check("gnt_gap", 32'(prev_gnt), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(l_gnt) + 32'd2, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_is_gnt", 32'(e.kind == EV_GNT), 32'd1);
          check("gnt_owner", 32'(l_gnt), 32'(e.who));
          if (e.kind == EV_GNT && !e.we) begin
            rv_pending = 1'b1;
            rv_who     = e.who;
            rv_data    = e.rdata;
          end
        end
        last_gnt_cyc = cyc;
      end

      if (lock_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lock_err", 32'(lock_err), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_is_lock_err", 32'(e.kind == EV_ERR), 32'd1);
          check("lock_err_delay", 32'(cyc - last_gnt_cyc), 32'(LOCK_TMO + 1));
        end
      end

      prev_gnt = c_gnt || l_gnt;
    end
  end

  // ------------------------------------------------------------- stimulus ---
  initial begin : stim
    int waited;
    RST = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 check_outputs_zero("in_reset");
    do_reset();
    check_outputs_zero("after_reset");

    // Reset lands during the grant cycle of a loader write: it must not commit.
    set_port(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'h5A);
    waited = 0;
    do begin
      @(posedge CLK); #1;
      waited++;
    end while (!l_gnt && waited < 20);
    check("rst_test_l_gnt", 32'(l_gnt), 32'd1);
    #2 RST = 1'b1;
    #1 check_outputs_zero("mid_gnt_reset");
    set_port(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    mdl_reset();
    check_outputs_zero("released");
    round_single(1'b0, mk(1'b0, 1'b0, 4'd3, '0, -1));   // expect 0x00

    // Continuous contention straight after reset: CPU, loader, CPU, loader.
    do_reset();
    round_pair(2, 2);

    // Loader writes 0x11 to addr 2, CPU reads it back.
    round_single(1'b1, mk(1'b1, 1'b0, 4'd2, 8'h11, -1));
    round_single(1'b0, mk(1'b0, 1'b0, 4'd2, '0, -1));

    // Locked doubling of mem[5] = 0x21 while the loader waits to read it.
    round_single(1'b1, mk(1'b1, 1'b0, 4'd5, 8'h21, -1));
    round_lock(1'b0, 4'd5, 1'b0, mk(1'b0, 1'b0, 4'd5, '0, -1), 1'b0);
    round_single(1'b1, mk(1'b0, 1'b0, 4'd5, '0, -1));   // still 0x42

    // Abandoned CPU lock while the loader waits.
    round_lock(1'b0, 4'd7, 1'b0, mk(1'b0, 1'b0, 4'd7, '0, -1), 1'b1);

    for (int r = 0; r < 160; r++) begin
      case ($urandom_range(0, 5))
        0, 1: round_single(1'($urandom_range(0, 1)), rnd_tx());
        2, 3: round_pair(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        4:    round_lock(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), rnd_tx(), 1'b0);
        default: round_lock(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                            1'b0, rnd_tx(), 1'b1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
